// File: rtl/pulse_event_pacer_pkg.sv
// Shared encodings and constants for the pulse pacer feeding the clkA->clkB pulse synchronizer.
package pulse_event_pacer_pkg;

    typedef enum logic {
        PACER_IDLE = 1'b0,
        PACER_GAP  = 1'b1
    } pacer_state_e;

    // Default spacing; also used by the top-level integration of the synchronizer.
    localparam int PULSE_SYNC_DEFAULT_GAP = 24;

endpackage

// File: rtl/pulse_event_pacer.sv
// Counts event strobes and replays them as single-cycle pulses spaced MIN_GAP cycles apart,
// so the downstream four-phase pulse synchronizer never sees a pulse before its ack loop completes.
module pulse_event_pacer
    import pulse_event_pacer_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int MIN_GAP   = PULSE_SYNC_DEFAULT_GAP
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 event_in,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 clr_overflow,
    output logic                 pulse_out,
    output logic [CNT_WIDTH-1:0] pending,
    output logic                 busy,
    output logic                 overflow,
    output logic                 dbg_state
);

    localparam int                   GAP_W    = $clog2(MIN_GAP);
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(MIN_GAP - 1);
    localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    pacer_state_e         state_q, state_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic                 pulse_q, pulse_d;

    logic issue;
    logic at_max;
    logic drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PACER_IDLE;
            gap_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pulse_q    <= pulse_d;
        end
    end

    always_comb begin
        issue  = (state_q == PACER_IDLE) && enable && (pending_q != '0) && !flush;
        at_max = (pending_q == CNT_MAX);
        // An event is lost only when the counter is full and nothing leaves this cycle.
        drop   = event_in && at_max && !issue && !flush;

        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            PACER_IDLE: begin
                if (issue) begin
                    state_d = PACER_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            PACER_GAP: begin
                // Flush does not shorten the gap: the synchronizer may still be mid-handshake.
                if (gap_q <= GAP_ONE) begin
                    state_d = PACER_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = PACER_IDLE;
                gap_d   = '0;
            end
        endcase

        pending_d = pending_q;
        if (flush) begin
            pending_d = CNT_WIDTH'(event_in);
        end else if (issue && !event_in) begin
            pending_d = pending_q - CNT_WIDTH'(1);
        end else if (!issue && event_in && !at_max) begin
            pending_d = pending_q + CNT_WIDTH'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        pulse_d = issue;
    end

    assign pulse_out = pulse_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != PACER_IDLE) || (pending_q != '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_event_pacer.sv
// Self-checking bench for pulse_event_pacer: expected pulse cycles are queued at stimulus time
// and matched against observed pulse_out highs.
module tb_pulse_event_pacer;

    localparam int CW  = 3;
    localparam int GAP = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          event_in = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          pulse_out;
    logic [CW-1:0] pending;
    logic          busy;
    logic          overflow;
    logic          dbg_state;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [31:0]   exp_q[$];

    pulse_event_pacer #(.CNT_WIDTH(CW), .MIN_GAP(GAP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .event_in     (event_in),
        .enable       (enable),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .pulse_out    (pulse_out),
        .pending      (pending),
        .busy         (busy),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every observed pulse must match the oldest expected pulse cycle
    always @(negedge clk) begin
        if (reset_n && pulse_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_time: pulse at cycle %0d, no pulse expected", cyc);
            end else begin
                if (exp_q[0] !== 32'(cyc)) begin
                    errors++;
                    $display("FAIL pulse_time: pulse at cycle %0d, expected cycle %0d", cyc, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b after %0d cycles, required 0", busy, budget);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d expected pulses not seen, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks++;
        if ({pulse_out, pending, busy, overflow, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_state: pulse=%b pending=%0d busy=%b ovf=%b state=%b, required all 0",
                     pulse_out, pending, busy, overflow, dbg_state);
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        int t;
        t = cyc;
        event_in = 1'b1;
        exp_q.push_back(32'(t + 2));
        tick(1);
        event_in = 1'b0;
        checks++;
        if (pending !== 3'd1) begin
            errors++; $display("FAIL single_pending1: pending=%0d, required 1", pending);
        end
        tick(1);
        checks++;
        if (pending !== 3'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_pending0: pending=%0d busy=%b, required 0/1", pending, busy);
        end
        repeat (GAP - 1) begin
            tick(1);
            checks++;
            if (busy !== ((cyc < t + 25) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL single_busy: cycle %0d busy=%b, required %b", cyc - t, busy, cyc < t + 25);
            end
        end
        drain(10);
    endtask

    task automatic test_burst();
        int t;
        logic [CW-1:0] peak;
        t = cyc;
        peak = '0;
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(t + 2 + GAP * k));
        for (int i = 0; i < 8; i++) begin
            event_in = (i < 5);
            tick(1);
            if (pending > peak) peak = pending;
        end
        event_in = 1'b0;
        drain(150);
        checks++;
        if (peak !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL burst_peak: peak=%0d ovf=%b, required 4/0", peak, overflow);
        end
    endtask

    task automatic test_saturation();
        int s;
        enable = 1'b0;
        repeat (10) begin
            event_in = 1'b1;
            tick(1);
        end
        event_in = 1'b0;
        tick(1);
        checks++;
        if (pending !== 3'd7 || overflow !== 1'b1 || busy !== 1'b1 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL sat_fill: pending=%0d ovf=%b busy=%b state=%b, required 7/1/1/0",
                     pending, overflow, busy, dbg_state);
        end
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL sat_clear: ovf=%b, required 0", overflow);
        end
        event_in = 1'b1;
        clr_overflow = 1'b1;
        tick(1);
        event_in = 1'b0;
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b1 || pending !== 3'd7) begin
            errors++; $display("FAIL sat_set_wins: ovf=%b pending=%0d, required 1/7", overflow, pending);
        end
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        s = cyc;
        enable = 1'b1;
        for (int k = 0; k < 7; k++) exp_q.push_back(32'(s + 1 + GAP * k));
        drain(7 * GAP + 20);
        checks++;
        if (pending !== 3'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL sat_drain: pending=%0d ovf=%b, required 0/0", pending, overflow);
        end
    endtask

    task automatic test_simultaneity();
        int t;
        int s;
        t = cyc;
        exp_q.push_back(32'(t + 2));
        exp_q.push_back(32'(t + 2 + GAP));
        event_in = 1'b1;
        tick(2);
        event_in = 1'b0;
        checks++;
        if (pending !== 3'd1) begin
            errors++; $display("FAIL simul_pending: pending=%0d, required 1", pending);
        end
        drain(60);
        enable = 1'b0;
        event_in = 1'b1;
        tick(7);
        event_in = 1'b0;
        checks++;
        if (pending !== 3'd7) begin
            errors++; $display("FAIL simul_fill: pending=%0d, required 7", pending);
        end
        s = cyc;
        enable = 1'b1;
        event_in = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(s + 1 + GAP * k));
        tick(1);
        event_in = 1'b0;
        checks++;
        if (pending !== 3'd7 || overflow !== 1'b0) begin
            errors++; $display("FAIL simul_max: pending=%0d ovf=%b, required 7/0", pending, overflow);
        end
        drain(8 * GAP + 20);
    endtask

    task automatic test_flush_mid_gap();
        int s;
        int v;
        enable = 1'b0;
        event_in = 1'b1;
        tick(4);
        event_in = 1'b0;
        s = cyc;
        enable = 1'b1;
        exp_q.push_back(32'(s + 1));
        tick(4);
        checks++;
        if (pending !== 3'd3 || dbg_state !== 1'b1) begin
            errors++; $display("FAIL flush_pre: pending=%0d state=%b, required 3/1", pending, dbg_state);
        end
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        checks++;
        if (pending !== 3'd0) begin
            errors++; $display("FAIL flush_pending: pending=%0d, required 0", pending);
        end
        repeat (18) begin
            tick(1);
            checks++;
            if (busy !== ((cyc < s + 24) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL flush_busy: cycle %0d busy=%b, required %b", cyc - s, busy, cyc < s + 24);
            end
        end
        tick(40);
        drain(5);
        enable = 1'b0;
        event_in = 1'b1;
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        event_in = 1'b0;
        checks++;
        if (pending !== 3'd1) begin
            errors++; $display("FAIL flush_survive: pending=%0d, required 1", pending);
        end
        v = cyc;
        enable = 1'b1;
        exp_q.push_back(32'(v + 1));
        drain(40);
    endtask

    task automatic test_async_reset();
        int t;
        int r;
        t = cyc;
        exp_q.push_back(32'(t + 2));
        event_in = 1'b1;
        tick(2);
        event_in = 1'b0;
        tick(4);
        checks++;
        if (pending !== 3'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre: pending=%0d busy=%b, required 1/1", pending, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pulse_out, pending, busy, overflow, dbg_state} !== '0) begin
            errors++;
            $display("FAIL areset_async: pulse=%b pending=%0d busy=%b ovf=%b state=%b, required all 0",
                     pulse_out, pending, busy, overflow, dbg_state);
        end
        tick(2);
        reset_n = 1'b1;
        tick(1);
        r = cyc;
        exp_q.push_back(32'(r + 2));
        event_in = 1'b1;
        tick(1);
        event_in = 1'b0;
        drain(40);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_saturation();
        test_simultaneity();
        test_flush_mid_gap();
        test_async_reset();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
